// File: rtl/display_pkg.sv
// Shared constants for the paged 7-segment scanner: segment codes, page modes
// and controller states.
package display_pkg;

  localparam logic [7:0] SEG_0    = 8'hFC;
  localparam logic [7:0] SEG_1    = 8'h60;
  localparam logic [7:0] SEG_2    = 8'hDA;
  localparam logic [7:0] SEG_3    = 8'hF2;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'hB6;
  localparam logic [7:0] SEG_6    = 8'hBE;
  localparam logic [7:0] SEG_7    = 8'hE0;
  localparam logic [7:0] SEG_8    = 8'hFE;
  localparam logic [7:0] SEG_9    = 8'hF6;
  localparam logic [7:0] SEG_DASH = 8'h02;
  localparam logic [7:0] SEG_OFF  = 8'h00;

  localparam logic [1:0] MODE_WRAP   = 2'b00;
  localparam logic [1:0] MODE_STOP   = 2'b01;
  localparam logic [1:0] MODE_MANUAL = 2'b10;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_CONV,
    ST_DISP
  } state_t;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// Combinational BCD digit to active-high {a..g,dp} segment pattern.
module bcd_seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_page_scanner.sv
// Paged multi-channel 7-segment scanner: the selected channel is converted by a
// sequential double dabble into a shadow BCD register that the digit scan shows.
module seg_page_scanner
  import display_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int VAL_W    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 50000,
  parameter int PAGE_DIV = 50000000
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_CH*VAL_W-1:0]   vals,
  input  logic [1:0]                mode,
  input  logic                      step,
  input  logic                      blank_lz,
  output logic [DIGITS-1:0]         digit,
  output logic [7:0]                seg_data,
  output logic [$clog2(NUM_CH)-1:0] page,
  output logic                      busy
);

  localparam int PW  = $clog2(NUM_CH);
  localparam int BW  = 4 * DIGITS;
  localparam int CW  = $clog2(VAL_W);
  localparam int SCW = $clog2(SCAN_DIV);
  localparam int PGW = $clog2(PAGE_DIV);
  localparam int SLW = $clog2(DIGITS + 1);
  localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;

  localparam logic [CW-1:0]  CNT_LAST = CW'(VAL_W - 1);
  localparam logic [SCW-1:0] SC_LAST  = SCW'(SCAN_DIV - 1);
  localparam logic [PGW-1:0] PG_LAST  = PGW'(PAGE_DIV - 1);
  localparam logic [SLW-1:0] SL_LAST  = SLW'(DIGITS);
  localparam logic [PW-1:0]  PG_MAX   = PW'(NUM_CH - 1);

  state_t            state_q, state_d;
  logic [PW-1:0]     page_q;
  logic              pend_q;
  logic [1:0]        mode_q;
  logic [PGW-1:0]    pg_cnt_q;
  logic [SCW-1:0]    sc_cnt_q;
  logic [SLW-1:0]    slot_q;
  logic [VAL_W-1:0]  snap_q, bin_q;
  logic [BW-1:0]     bcd_q, shadow_q;
  logic [CW-1:0]     bit_cnt_q;
  logic              shadow_vld_q, ovf_q;
  logic [DIGITS-1:0] digit_q, digit_d;
  logic [7:0]        seg_q, seg_d, dec_seg;

  logic [VAL_W-1:0]  cur_val, bin_shift;
  logic [BW-1:0]     bcd_adj, bcd_shift;
  logic [PW-1:0]     next_page;
  logic [SLW-1:0]    pos;
  logic [3:0]        nib;
  logic              auto_mode, pg_tick, sc_tick, at_last, adv_req, take_adv, conv_last;
  logic              snap_over, lead_zero;

  assign cur_val   = vals[int'(page_q)*VAL_W +: VAL_W];
  assign auto_mode = ~mode[1];
  assign pg_tick   = auto_mode && (pg_cnt_q == PG_LAST);
  assign sc_tick   = (sc_cnt_q == SC_LAST);
  assign at_last   = (page_q == PG_MAX);
  assign next_page = at_last ? '0 : page_q + 1'b1;
  // Auto-stop parks on the last page without raising a request, so no reload happens.
  assign adv_req   = (pg_tick && !(mode == MODE_STOP && at_last)) || (mode[1] && step);
  assign take_adv  = (state_q == ST_DISP) && (adv_req || pend_q);
  assign conv_last = (state_q == ST_CONV) && (bit_cnt_q == CNT_LAST);
  assign snap_over = {{(32-VAL_W){1'b0}}, snap_q} > MAX_VAL;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD: state_d = ST_CONV;
      ST_CONV: if (bit_cnt_q == CNT_LAST) state_d = ST_DISP;
      ST_DISP: if (take_adv || cur_val != snap_q) state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift the pair left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[BW-2:0], bin_q[VAL_W-1]};
    bin_shift = {bin_q[VAL_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_LOAD;
    else         state_q <= state_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      snap_q       <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      bit_cnt_q    <= '0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      if (state_q == ST_LOAD) begin
        snap_q    <= cur_val;
        bin_q     <= cur_val;
        bcd_q     <= '0;
        bit_cnt_q <= '0;
      end else if (state_q == ST_CONV) begin
        bcd_q     <= bcd_shift;
        bin_q     <= bin_shift;
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (conv_last) begin
        shadow_q     <= bcd_shift;
        ovf_q        <= snap_over;
        shadow_vld_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      page_q   <= '0;
      pend_q   <= 1'b0;
      mode_q   <= MODE_WRAP;
      pg_cnt_q <= '0;
    end else begin
      mode_q <= mode;
      if (take_adv) begin
        page_q <= next_page;
        pend_q <= 1'b0;
      end else if (adv_req && state_q != ST_DISP) begin
        pend_q <= 1'b1;
      end
      if (take_adv || mode != mode_q || !auto_mode || pg_tick) pg_cnt_q <= '0;
      else                                                    pg_cnt_q <= pg_cnt_q + 1'b1;
    end
  end

  // Slot 0 is a dark slot between scans; slot k shows digit position DIGITS-k.
  always_comb begin
    pos       = SL_LAST - slot_q;
    nib       = shadow_q[{pos, 2'b00} +: 4];
    lead_zero = blank_lz && (pos != '0) && ((shadow_q >> {pos, 2'b00}) == '0);
    digit_d   = '0;
    seg_d     = SEG_OFF;
    if (slot_q != '0) begin
      digit_d = DIGITS'(1) << pos;
      if (!shadow_vld_q)  seg_d = SEG_OFF;
      else if (ovf_q)     seg_d = SEG_DASH;
      else if (lead_zero) seg_d = SEG_OFF;
      else                seg_d = dec_seg;
    end
  end

  bcd_seg_decoder u_dec (
    .bcd_i (nib),
    .seg_o (dec_seg)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sc_cnt_q <= '0;
      slot_q   <= '0;
      digit_q  <= '0;
      seg_q    <= SEG_OFF;
    end else begin
      sc_cnt_q <= sc_tick ? '0 : sc_cnt_q + 1'b1;
      if (sc_tick) slot_q <= (slot_q == SL_LAST) ? '0 : slot_q + 1'b1;
      digit_q <= digit_d;
      seg_q   <= seg_d;
    end
  end

  assign digit    = digit_q;
  assign seg_data = seg_q;
  assign page     = page_q;
  assign busy     = (state_q == ST_CONV);

endmodule

// File: tb/tb_seg_page_scanner.sv
// Self-checking bench for seg_page_scanner: vector table and scoreboard of scan
// frames, plus sequences for paging, live refresh, overflow and reset.
module tb_seg_page_scanner;

  localparam int NUM_CH = 4, VAL_W = 8, DIGITS = 3, SCAN_DIV = 4, PAGE_DIV = 200;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic [NUM_CH*VAL_W-1:0] vals;
  logic [1:0]              mode;
  logic                    step, blank_lz;
  logic [DIGITS-1:0]       digit;
  logic [7:0]              seg_data;
  logic [1:0]              page;
  logic                    busy;

  logic [19:0] vals10;
  logic [1:0]  mode10;
  logic        step10, blz10;
  logic [2:0]  digit10;
  logic [7:0]  seg10;
  logic [0:0]  page10;
  logic        busy10;

  seg_page_scanner #(.NUM_CH(NUM_CH), .VAL_W(VAL_W), .DIGITS(DIGITS),
                     .SCAN_DIV(SCAN_DIV), .PAGE_DIV(PAGE_DIV)) dut (
    .clk(clk), .resetn(resetn), .vals(vals), .mode(mode), .step(step),
    .blank_lz(blank_lz), .digit(digit), .seg_data(seg_data), .page(page), .busy(busy)
  );

  seg_page_scanner #(.NUM_CH(2), .VAL_W(10), .DIGITS(3),
                     .SCAN_DIV(SCAN_DIV), .PAGE_DIV(PAGE_DIV)) dut10 (
    .clk(clk), .resetn(resetn), .vals(vals10), .mode(mode10), .step(step10),
    .blank_lz(blz10), .digit(digit10), .seg_data(seg10), .page(page10), .busy(busy10)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct { logic [2:0] dig; logic [7:0] seg; } frame_t;
  frame_t exp_q[$];

  typedef struct { logic [7:0] val; logic blz; logic [7:0] s2, s1, s0; } vec_t;
  vec_t vecs[12];

  logic       use10 = 1'b0;
  logic [2:0] mon_digit;
  logic [7:0] mon_seg;
  assign mon_digit = use10 ? digit10 : digit;
  assign mon_seg   = use10 ? seg10 : seg_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string name, output int n);
    n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== lvl) timeout(name);
  endtask

  task automatic set_ch(input int k, input logic [7:0] v);
    vals[k*VAL_W +: VAL_W] = v;
  endtask

  task automatic settle(input string name);
    int n;
    wait_busy(1'b1, 6, {name, " start"}, n);
    wait_busy(1'b0, 20, {name, " end"}, n);
    repeat (2) @(negedge clk);
  endtask

  task automatic push_exp(input logic [7:0] s2, input logic [7:0] s1, input logic [7:0] s0);
    exp_q.push_back('{3'b100, s2});
    exp_q.push_back('{3'b010, s1});
    exp_q.push_back('{3'b001, s0});
  endtask

  task automatic capture_frame(input string name);
    int n = 0;
    while (mon_digit !== 3'b100 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (mon_digit !== 3'b100) begin
      timeout(name);
      exp_q.delete();
      return;
    end
    for (int i = 0; i < DIGITS; i++) begin
      frame_t e;
      e = exp_q.pop_front();
      check({name, " digit"}, 32'(mon_digit), 32'(e.dig));
      check({name, " seg"}, 32'(mon_seg), 32'(e.seg));
      repeat (SCAN_DIV) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, cnt, n, start, bad, rises;
    logic [7:0] prev;
    logic busy_prev;

    vecs[0]  = '{8'd255, 1'b0, 8'hDA, 8'hB6, 8'hB6};
    vecs[1]  = '{8'd1,   1'b1, 8'h00, 8'h00, 8'h60};
    vecs[2]  = '{8'd1,   1'b0, 8'hFC, 8'hFC, 8'h60};
    vecs[3]  = '{8'd0,   1'b1, 8'h00, 8'h00, 8'hFC};
    vecs[4]  = '{8'd0,   1'b0, 8'hFC, 8'hFC, 8'hFC};
    vecs[5]  = '{8'd9,   1'b1, 8'h00, 8'h00, 8'hF6};
    vecs[6]  = '{8'd10,  1'b1, 8'h00, 8'h60, 8'hFC};
    vecs[7]  = '{8'd100, 1'b1, 8'h60, 8'hFC, 8'hFC};
    vecs[8]  = '{8'd207, 1'b1, 8'hDA, 8'hFC, 8'hE0};
    vecs[9]  = '{8'd38,  1'b0, 8'hFC, 8'hF2, 8'hFE};
    vecs[10] = '{8'd64,  1'b1, 8'h00, 8'hBE, 8'h66};
    vecs[11] = '{8'd199, 1'b0, 8'h60, 8'hF6, 8'hF6};

    resetn = 1'b0;
    vals = '0;
    mode = 2'b10;
    step = 1'b0;
    blank_lz = 1'b0;
    vals10 = {10'd0, 10'd1000};
    mode10 = 2'b10;
    step10 = 1'b0;
    blz10 = 1'b0;
    repeat (3) @(negedge clk);

    check("reset digit", 32'(digit), 32'(0));
    check("reset seg", 32'(seg_data), 32'(0));
    check("reset page", 32'(page), 32'(0));
    check("reset busy", 32'(busy), 32'(0));

    // Conversion window right after reset release
    set_ch(0, 8'd255);
    resetn = 1'b1;
    first = -1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
      @(negedge clk);
    end
    check("busy length", 32'(cnt), 32'(VAL_W));
    check("busy start", 32'(first), 32'(1));
    push_exp(8'hDA, 8'hB6, 8'hB6);
    capture_frame("frame 255");
    check("ghost slot digit", 32'(digit), 32'(0));
    check("ghost slot seg", 32'(seg_data), 32'(0));

    // Overflow on the 10-bit instance
    use10 = 1'b1;
    push_exp(8'h02, 8'h02, 8'h02);
    capture_frame("overflow 1000");
    use10 = 1'b0;

    // Vector table on channel 0, manual mode
    prev = 8'd255;
    foreach (vecs[i]) begin
      blank_lz = vecs[i].blz;
      if (vecs[i].val != prev) begin
        set_ch(0, vecs[i].val);
        settle($sformatf("vec%0d conv", i));
      end else begin
        repeat (3) @(negedge clk);
      end
      prev = vecs[i].val;
      push_exp(vecs[i].s2, vecs[i].s1, vecs[i].s0);
      capture_frame($sformatf("vec%0d", i));
    end

    // Live refresh 9 -> 10 with blanking
    blank_lz = 1'b1;
    set_ch(0, 8'd9);
    settle("refresh setup");
    set_ch(0, 8'd10);
    wait_busy(1'b1, 6, "refresh start", n);
    check("refresh latency ok", 32'(n <= 2), 32'(1));
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (digit === 3'b001 && seg_data !== 8'hF6 && seg_data !== 8'hFC) bad++;
      if (digit === 3'b010 && seg_data !== 8'h00 && seg_data !== 8'h60) bad++;
      if (digit === 3'b100 && seg_data !== 8'h00) bad++;
      @(negedge clk);
    end
    check("refresh no blank frame", 32'(bad), 32'(0));
    push_exp(8'h00, 8'h60, 8'hFC);
    capture_frame("refresh 10");

    // Auto-stop: park on the last page and stay idle
    set_ch(1, 8'd2);
    set_ch(2, 8'd3);
    set_ch(3, 8'd4);
    mode = 2'b01;
    repeat (700) @(negedge clk);
    check("stop page", 32'(page), 32'(3));
    rises = 0;
    busy_prev = busy;
    step = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      step = 1'b0;
      if (busy === 1'b1 && busy_prev !== 1'b1) rises++;
      busy_prev = busy;
    end
    check("stop idle loads", 32'(rises), 32'(0));
    check("stop ignores step", 32'(page), 32'(3));
    set_ch(3, 8'd44);
    settle("stop refresh");

    // Manual step wraps from the last page
    mode = 2'b10;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    check("manual wrap", 32'(page), 32'(0));
    wait_busy(1'b0, 20, "manual settle", n);
    repeat (2) @(negedge clk);

    // Steps during a conversion: first is held, second is dropped
    set_ch(0, 8'd77);
    wait_busy(1'b1, 6, "pend conv", n);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("page held in conv", 32'(page), 32'(0));
    repeat (2) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_busy(1'b0, 20, "pend conv end", n);
    check("page before take", 32'(page), 32'(0));
    @(negedge clk);
    check("pending taken", 32'(page), 32'(1));
    repeat (40) @(negedge clk);
    check("second step dropped", 32'(page), 32'(1));

    // Asynchronous reset in the middle of a conversion
    set_ch(1, 8'd99);
    wait_busy(1'b1, 6, "reset conv", n);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midconv digit", 32'(digit), 32'(0));
    check("midconv seg", 32'(seg_data), 32'(0));
    check("midconv busy", 32'(busy), 32'(0));
    check("midconv page", 32'(page), 32'(0));

    // Auto-wrap paging
    mode = 2'b00;
    blank_lz = 1'b1;
    set_ch(0, 8'd1);
    set_ch(1, 8'd2);
    set_ch(2, 8'd3);
    set_ch(3, 8'd4);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    start = cyc;
    push_exp(8'h00, 8'h00, 8'h60);
    capture_frame("wrap ch0");
    while (cyc < start + 205) @(negedge clk);
    check("wrap page 1", 32'(page), 32'(1));
    while (cyc < start + 405) @(negedge clk);
    check("wrap page 2", 32'(page), 32'(2));
    while (cyc < start + 605) @(negedge clk);
    check("wrap page 3", 32'(page), 32'(3));
    while (cyc < start + 805) @(negedge clk);
    check("wrap page 0", 32'(page), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
